multi_key_debounce: RTL and testbench
=====================================

Name: multi_key_debounce

Overview:
N-channel push-button conditioner and the parametrised successor of the single-key debouncer. Each channel synchronises a raw pin and debounces it with a configurable stable-time count. It then produces a debounced level plus one-cycle press, release, long-press and auto-repeat event pulses. Sits between board buttons and the UI/control FSMs; an optional sample tick lets one prescaler serve all channels.

Parameters:
N_KEYS, 4, number of independent key channels (>=1)
DEBOUNCE_CYCLES, 100000, consecutive mismatching ticks required to accept a level change (>=1)
LONG_PRESS_CYCLES, 50000000, ticks after key_press at which key_long fires (must be > DEBOUNCE_CYCLES); 0 disables long/repeat
REPEAT_CYCLES, 10000000, tick period of key_repeat after key_long; 0 disables repeat
ACTIVE_LOW, 1, 1: a raw pin reads 0 when pressed; 0: a raw pin reads 1 when pressed

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  sample enable; counters advance only when 1 (tie high for per-clock counting)
key_in  in  N_KEYS  raw asynchronous key pins
key_level  out  N_KEYS  debounced pressed state (1 = pressed, polarity-normalised)
key_press  out  N_KEYS  one-clk pulse on debounced press
key_release  out  N_KEYS  one-clk pulse on debounced release
key_long  out  N_KEYS  one-clk pulse when hold reaches LONG_PRESS_CYCLES
key_repeat  out  N_KEYS  one-clk pulse every REPEAT_CYCLES after key_long while held

Behaviour:
- Reset: all outputs 0. Sync flops are preset to the released pin value (1 if ACTIVE_LOW, else 0). All counters are 0 and every channel is in RELEASED.
- Sync: 2-flop synchroniser per channel, always clocked (not gated by tick). The synchronised value is normalised so that pressed = 1.
- Debounce counter (per channel): on a tick where the sync value != key_level, increment. On any cycle where they are equal, clear immediately, regardless of tick.
- When the count reaches DEBOUNCE_CYCLES, key_level toggles and the count clears. With tick=1, a clean edge on key_in changes key_level exactly DEBOUNCE_CYCLES+2 clocks later.
- A glitch shorter than DEBOUNCE_CYCLES ticks produces no output change.
- Channel FSM states: RELEASED, PRESSED, LONG_HELD.
  - RELEASED -> PRESSED when key_level rises. key_press pulses in the same cycle key_level goes 1. The hold counter is cleared.
  - PRESSED: the hold counter increments per tick. When it reaches LONG_PRESS_CYCLES, pulse key_long, go to LONG_HELD and clear the repeat counter.
  - LONG_HELD: the repeat counter increments per tick. Each time it reaches REPEAT_CYCLES, pulse key_repeat and clear it. If REPEAT_CYCLES=0, no repeats occur.
  - PRESSED/LONG_HELD -> RELEASED when key_level falls. key_release pulses in the same cycle key_level goes 0. Pending long or repeat events are cancelled.
- With tick=1: key_long is asserted LONG_PRESS_CYCLES clocks after key_press. Repeats follow at LONG_PRESS_CYCLES + k*REPEAT_CYCLES, k>=1.
- Bounce during a hold that is shorter than the debounce window does not disturb the hold or repeat counters.
- Simultaneous events:
  - Channels are fully independent; any combination of pulses may assert in one cycle on different bits.
  - On a single channel, at most one of press/release/long/repeat fires per cycle.
  - If release debounces in the same cycle a long or repeat would fire, release wins and the other is suppressed.
- Counter widths are $clog2(max parameter + 1). Counters never wrap, because each clears at its terminal value.
- tick=0 freezes all counters but not the synchroniser or the mismatch-clear. Pulses are only generated on cycles where a counter reaches its terminal value.
- Reset asserted mid-hold: immediate return to the reset state. No release pulse is produced.

Decomposition:
- Shared package/header: channel state encodings (RELEASED=2'd0, PRESSED=2'd1, LONG_HELD=2'd2) and a clog2-based width helper.
- One sub-module, key_channel, implements the synchroniser, debounce counter, FSM and hold/repeat counters for one key. The top generates N_KEYS instances and concatenates their outputs.

Test Plan:
- Reset then idle, ACTIVE_LOW=1, key_in all 1 -> every output stays 0 for 1000 clocks.
- DEBOUNCE_CYCLES=4, tick=1; drive key_in[0] 1->0 cleanly at clk 10 -> key_level[0]=1 and key_press[0] pulse at clk 16; release at clk 40 -> key_release[0] pulse at clk 46.
- Bounce: key_in[1] low for 3 clocks, high for 2, low for 3, then high -> no pulses on key_level[1] or any event output.
- LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8; hold key 2 low for 60 clocks -> key_press at T, key_long at T+20, key_repeat at T+28, T+36; release gives exactly one key_release and no further repeats.
- tick asserted every 4th clock with DEBOUNCE_CYCLES=4 -> key_level latency is 16 clocks (+/-3 for phase) plus 2 sync clocks; a 10-clock glitch is rejected.
- Keys 0 and 3 pressed in the same clock -> both key_press bits assert in the same cycle. Assert rst_n=0 mid-hold -> all outputs 0 immediately and no key_release after reset deasserts while key_in is released.

Source files
------------

// File: rtl/multi_key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// multi_key_debounce_pkg
// Shared channel-state encodings and counter width helper for the
// multi-key debouncer.
// Revision: 1.0
// ============================================================================
package multi_key_debounce_pkg;

  typedef logic [1:0] chan_state_t;

  localparam chan_state_t RELEASED  = 2'd0;
  localparam chan_state_t PRESSED   = 2'd1;
  localparam chan_state_t LONG_HELD = 2'd2;

  // Width of a counter that must hold values 0..max_val; never below one bit
  // so that a disabled (zero) terminal count still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_key_debounce_if.sv
`default_nettype none
// ============================================================================
// multi_key_debounce_if
// Key bundle: raw pins and sample tick in, conditioned level and event
// pulses out. The master side drives pins, the slave side is the debouncer.
// Revision: 1.0
// ============================================================================
interface multi_key_debounce_if #(
  parameter int N_KEYS = 4
) ();

  logic              tick;
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] key_repeat;

  modport master (
    output tick, key_in,
    input  key_level, key_press, key_release, key_long, key_repeat
  );

  modport slave (
    input  tick, key_in,
    output key_level, key_press, key_release, key_long, key_repeat
  );

endinterface
`default_nettype wire

// File: rtl/multi_key_debounce_key_channel.sv
`default_nettype none
// ============================================================================
// key_channel
// One key: 2-flop synchroniser, tick-gated debounce counter, and a
// RELEASED/PRESSED/LONG_HELD tracker producing press, release, long-press
// and auto-repeat pulses.
// Revision: 1.0
// ============================================================================
module key_channel
  import multi_key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 100000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam int REP_W  = cnt_width(REPEAT_CYCLES);

  localparam bit LONG_EN = (LONG_PRESS_CYCLES > 0);
  localparam bit REP_EN  = LONG_EN && (REPEAT_CYCLES > 0);

  // Terminal values are one below the count because the final tick itself
  // is the event, not a tick after it.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_EN ? LONG_PRESS_CYCLES - 1 : 0);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_EN ? REPEAT_CYCLES - 1 : 0);

  localparam logic RELEASED_PIN = (ACTIVE_LOW != 0);

  logic              sync1;
  logic              sync2;
  logic              pressed_raw;
  logic [DEB_W-1:0]  deb_cnt;
  logic              flip;
  logic              rise;
  logic              fall;
  chan_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;

  // Two-stage synchroniser, preset to the idle pin level so reset is quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RELEASED_PIN;
      sync2 <= RELEASED_PIN;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign pressed_raw = sync2 ^ RELEASED_PIN;
  assign flip        = tick && (pressed_raw != key_level) && (deb_cnt == DEB_LAST);
  assign rise        = flip && !key_level;
  assign fall        = flip && key_level;

  // Debounce: count mismatching ticks, drop the count on any agreeing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      key_level <= 1'b0;
    end else begin
      if (pressed_raw == key_level) begin
        deb_cnt <= '0;
      end else if (tick) begin
        deb_cnt <= (deb_cnt == DEB_LAST) ? '0 : deb_cnt + DEB_W'(1);
      end
      key_level <= key_level ^ flip;
    end
  end

  // Hold tracker: release always wins over a coincident long/repeat event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RELEASED;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      key_press   <= rise;
      key_release <= fall;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
      case (state)
        RELEASED: begin
          if (rise) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state <= RELEASED;
          end else if (tick && LONG_EN) begin
            if (hold_cnt == HOLD_LAST) begin
              key_long <= 1'b1;
              state    <= LONG_HELD;
              rep_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state <= RELEASED;
          end else if (tick && REP_EN) begin
            if (rep_cnt == REP_LAST) begin
              key_repeat <= 1'b1;
              rep_cnt    <= '0;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_key_debounce.sv
`default_nettype none
// ============================================================================
// multi_key_debounce
// N independent push-button conditioners sharing one sample tick.
// Revision: 1.0
// ============================================================================
module multi_key_debounce
  import multi_key_debounce_pkg::*;
#(
  parameter int N_KEYS            = 4,
  parameter int DEBOUNCE_CYCLES   = 100000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000,
  parameter int ACTIVE_LOW        = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  multi_key_debounce_if.slave keys
);

  logic [N_KEYS-1:0] level_v;
  logic [N_KEYS-1:0] press_v;
  logic [N_KEYS-1:0] release_v;
  logic [N_KEYS-1:0] long_v;
  logic [N_KEYS-1:0] repeat_v;

  generate
    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      key_channel #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .REPEAT_CYCLES     (REPEAT_CYCLES),
        .ACTIVE_LOW        (ACTIVE_LOW)
      ) u_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (keys.tick),
        .key_in      (keys.key_in[g]),
        .key_level   (level_v[g]),
        .key_press   (press_v[g]),
        .key_release (release_v[g]),
        .key_long    (long_v[g]),
        .key_repeat  (repeat_v[g])
      );
    end
  endgenerate

  assign keys.key_level   = level_v;
  assign keys.key_press   = press_v;
  assign keys.key_release = release_v;
  assign keys.key_long    = long_v;
  assign keys.key_repeat  = repeat_v;

endmodule
`default_nettype wire

// File: tb/tb_multi_key_debounce.sv
`default_nettype none
// ============================================================================
// tb_multi_key_debounce
// Scoreboard bench: a behavioural model queues expected events, a negedge
// monitor pops and compares them against the DUT pulses and level.
// Revision: 1.0
// ============================================================================
module tb_multi_key_debounce;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;
  localparam int ALOW = 1;
  localparam logic IDLE_PIN = (ALOW != 0);

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  multi_key_debounce_if #(.N_KEYS(N)) bus ();

  multi_key_debounce #(
    .N_KEYS            (N),
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG),
    .REPEAT_CYCLES     (REP),
    .ACTIVE_LOW        (ALOW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .keys  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int key;
    int kind;
  } ev_t;

  ev_t sbq[$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;

  // Reference model: pins seen two clocks late, a level flips after DEB
  // consecutive disagreeing ticks, and events are derived from the number
  // of ticks the key has been held since its press.
  logic [N-1:0] m_s1 = '1;
  logic [N-1:0] m_s2 = '1;
  logic [N-1:0] m_lvl = '0;
  int           mis[N];
  int           held[N];
  bit           m_fired;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1  = {N{IDLE_PIN}};
      m_s2  = {N{IDLE_PIN}};
      m_lvl = '0;
      for (int k = 0; k < N; k++) begin
        mis[k]  = 0;
        held[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < N; k++) begin
        m_fired = 1'b0;
        if ((m_s2[k] != IDLE_PIN) == m_lvl[k]) begin
          mis[k] = 0;
        end else if (bus.tick) begin
          mis[k]++;
          if (mis[k] == DEB) begin
            mis[k]   = 0;
            m_lvl[k] = ~m_lvl[k];
            m_fired  = 1'b1;
            held[k]  = 0;
            sbq.push_back('{cyc, k, m_lvl[k] ? K_PRESS : K_RELEASE});
          end
        end
        if (!m_fired && m_lvl[k] && bus.tick) begin
          held[k]++;
          if (held[k] == LONG)
            sbq.push_back('{cyc, k, K_LONG});
          else if (held[k] > LONG && ((held[k] - LONG) % REP) == 0)
            sbq.push_back('{cyc, k, K_REPEAT});
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.key_in;
    end
  end

  // Timing windows: the stimulus asks for a given event on a key inside
  // [lo, hi]; the monitor closes each request once.
  int win_kind[N];
  int win_lo[N];
  int win_hi[N];
  int win_id[N];
  int win_seen[N];

  function automatic bit dut_pulse(input int k, input int kind);
    case (kind)
      K_PRESS:   return bus.key_press[k] === 1'b1;
      K_RELEASE: return bus.key_release[k] === 1'b1;
      K_LONG:    return bus.key_long[k] === 1'b1;
      default:   return bus.key_repeat[k] === 1'b1;
    endcase
  endfunction

  ev_t mon_exp[$];
  ev_t mon_got[$];
  int  mon_n;

  // Monitor: compare this cycle's DUT events and level with the model.
  always @(negedge clk) begin
    mon_exp.delete();
    mon_got.delete();
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) mon_exp.push_back(sbq.pop_front());
    for (int k = 0; k < N; k++)
      for (int kd = 0; kd < 4; kd++)
        if (dut_pulse(k, kd)) mon_got.push_back('{cyc, k, kd});
    mon_n = (mon_exp.size() > mon_got.size()) ? mon_exp.size() : mon_got.size();
    for (int i = 0; i < mon_n; i++) begin
      tests++;
      if (i >= mon_exp.size()) begin
        fails++;
        $display("FAIL event cyc %0d: got key%0d kind%0d, expected none", cyc, mon_got[i].key, mon_got[i].kind);
      end else if (i >= mon_got.size()) begin
        fails++;
        $display("FAIL event cyc %0d: got none, expected key%0d kind%0d", cyc, mon_exp[i].key, mon_exp[i].kind);
      end else if (mon_got[i].key != mon_exp[i].key || mon_got[i].kind != mon_exp[i].kind) begin
        fails++;
        $display("FAIL event cyc %0d: got key%0d kind%0d, expected key%0d kind%0d",
                 cyc, mon_got[i].key, mon_got[i].kind, mon_exp[i].key, mon_exp[i].kind);
      end
    end
    tests++;
    if (bus.key_level !== m_lvl) begin
      fails++;
      $display("FAIL level cyc %0d: got %b, expected %b", cyc, bus.key_level, m_lvl);
    end
    for (int k = 0; k < N; k++) begin
      if (win_id[k] != win_seen[k]) begin
        if (dut_pulse(k, win_kind[k])) begin
          tests++;
          win_seen[k] = win_id[k];
          if (cyc < win_lo[k] || cyc > win_hi[k]) begin
            fails++;
            $display("FAIL timing key%0d kind%0d: got cyc %0d, expected %0d..%0d",
                     k, win_kind[k], cyc, win_lo[k], win_hi[k]);
          end
        end else if (cyc > win_hi[k]) begin
          tests++;
          fails++;
          win_seen[k] = win_id[k];
          $display("FAIL timing key%0d kind%0d: got no event by cyc %0d, expected %0d..%0d",
                   k, win_kind[k], cyc, win_lo[k], win_hi[k]);
        end
      end
    end
  end

  int tick_mode = 0;
  int phase     = 0;
  int cd[N];
  int c0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      phase++;
      case (tick_mode)
        0:       bus.tick = 1'b1;
        1:       bus.tick = ((phase % 4) == 0);
        default: bus.tick = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic set_win(input int k, input int kind, input int lo, input int hi);
    win_kind[k] = kind;
    win_lo[k]   = lo;
    win_hi[k]   = hi;
    win_id[k]   = win_id[k] + 1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      win_id[k] = 0;
      cd[k]     = 0;
    end
    bus.key_in = {N{IDLE_PIN}};
    bus.tick   = 1'b1;
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1000);

    // Clean press/release on key 0: level follows DEB+2 clocks after the pin.
    c0 = cyc;
    set_win(0, K_PRESS, c0 + DEB + 2, c0 + DEB + 2);
    bus.key_in[0] = 1'b0;
    step(30);
    c0 = cyc;
    set_win(0, K_RELEASE, c0 + DEB + 2, c0 + DEB + 2);
    bus.key_in[0] = 1'b1;
    step(20);

    // Bounce on key 1 shorter than the debounce window.
    bus.key_in[1] = 1'b0; step(3);
    bus.key_in[1] = 1'b1; step(2);
    bus.key_in[1] = 1'b0; step(3);
    bus.key_in[1] = 1'b1; step(20);

    // 60-clock hold on key 2: long at T+20, repeats every 8; the repeat
    // that would coincide with the release at T+60 must be suppressed.
    c0 = cyc;
    set_win(2, K_PRESS, c0 + 6, c0 + 6);
    bus.key_in[2] = 1'b0;
    step(10);
    set_win(2, K_LONG, c0 + 6 + LONG, c0 + 6 + LONG);
    step(20);
    set_win(2, K_REPEAT, c0 + 6 + LONG + REP, c0 + 6 + LONG + REP);
    step(30);
    set_win(2, K_RELEASE, c0 + 66, c0 + 66);
    bus.key_in[2] = 1'b1;
    step(30);

    // Tick every 4th clock: a 10-clock glitch is rejected, a clean press
    // lands 16 clocks (+/-3 phase) plus 2 sync clocks later.
    tick_mode = 1;
    step(4);
    bus.key_in[1] = 1'b0; step(10);
    bus.key_in[1] = 1'b1; step(30);
    c0 = cyc;
    set_win(3, K_PRESS, c0 + 15, c0 + 21);
    bus.key_in[3] = 1'b0; step(40);
    bus.key_in[3] = 1'b1; step(40);
    tick_mode = 0;
    step(5);

    // Keys 0 and 3 together, then reset mid-hold with pins released in reset.
    c0 = cyc;
    set_win(0, K_PRESS, c0 + 6, c0 + 6);
    set_win(3, K_PRESS, c0 + 6, c0 + 6);
    bus.key_in[0] = 1'b0;
    bus.key_in[3] = 1'b0;
    step(15);
    rst_n = 1'b0;
    step(3);
    bus.key_in = {N{IDLE_PIN}};
    step(2);
    rst_n = 1'b1;
    step(30);

    // Randomised holds of varying length under full-rate and random ticks.
    for (int b = 0; b < 4; b++) begin
      tick_mode = (b % 2 == 0) ? 0 : 2;
      for (int t = 0; t < 1000; t++) begin
        for (int k = 0; k < N; k++) begin
          if (cd[k] == 0) begin
            bus.key_in[k] = ~bus.key_in[k];
            cd[k] = $urandom_range(1, (b < 2) ? 60 : 12);
          end else begin
            cd[k]--;
          end
        end
        if (b == 1 && t == 500) rst_n = 1'b0;
        if (b == 1 && t == 503) rst_n = 1'b1;
        step(1);
      end
    end
    tick_mode = 0;
    bus.key_in = {N{IDLE_PIN}};
    step(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
